// File: rtl/alu_pkg.sv
// alu_pkg: ALUOp codes, RV32I opcode/funct3 constants and issue FSM states shared by the ALU and its controller.
package alu_pkg;
    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_OR    = 5'd6;
    localparam logic [4:0] ALU_AND   = 5'd7;
    localparam logic [4:0] ALU_SLL   = 5'd8;
    localparam logic [4:0] ALU_SRL   = 5'd9;
    localparam logic [4:0] ALU_SRA   = 5'd10;
    localparam logic [4:0] ALU_LUI   = 5'd11;
    localparam logic [4:0] ALU_AUIPC = 5'd12;
    localparam logic [4:0] ALU_BLTU  = 5'd13;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPT, ST_RESP} state_t;

    // alt selects SUB over ADD and SRA over SRL
    function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  arith_op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  arith_op = ALU_SLL;
            F3_SLT:  arith_op = ALU_SLT;
            F3_SLTU: arith_op = ALU_SLTU;
            F3_XOR:  arith_op = ALU_XOR;
            F3_SR:   arith_op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/rv32_alu_decode.sv
// rv32_alu_decode: maps an RV32I word onto ALU operation, immediate and branch/illegal flags.
module rv32_alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  alu_op,
    output logic        use_imm,
    output logic [31:0] imm,
    output logic        is_branch,
    output logic [2:0]  br_kind,
    output logic        is_lui,
    output logic        is_auipc,
    output logic        illegal
);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_u, imm_b;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    always_comb begin
        alu_op    = ALU_NOP;
        use_imm   = 1'b0;
        imm       = '0;
        is_branch = 1'b0;
        br_kind   = f3;
        is_lui    = 1'b0;
        is_auipc  = 1'b0;
        illegal   = 1'b1;
        case (opc)
            OPC_LUI: begin
                alu_op  = ALU_LUI;
                use_imm = 1'b1;
                imm     = imm_u;
                is_lui  = 1'b1;
                illegal = 1'b0;
            end
            OPC_AUIPC: begin
                alu_op   = ALU_AUIPC;
                use_imm  = 1'b1;
                imm      = imm_u;
                is_auipc = 1'b1;
                illegal  = 1'b0;
            end
            OPC_OPIMM, OPC_OP: begin
                use_imm = opc == OPC_OPIMM;
                imm     = imm_i;
                alu_op  = arith_op(f3, f7[5] & (f3 == F3_SR || (opc == OPC_OP && f3 == F3_ADD)));
                illegal = opc == OPC_OP ? !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == F3_ADD || f3 == F3_SR)))
                        : f3 == F3_SLL ? f7 != 7'h00
                        : f3 == F3_SR  ? !(f7 == 7'h00 || f7 == 7'h20) : 1'b0;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                imm       = imm_b;
                // signed compares go through SLT so A-B overflow cannot flip the result
                alu_op    = !f3[2] ? ALU_SUB : f3[1] ? ALU_BLTU : ALU_SLT;
                illegal   = f3[2:1] == 2'b01;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one RV32I op to the registered ALU, captures C/Zero and returns writeback or branch result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_pc,
    output logic [XLEN-1:0] alu_A,
    output logic [XLEN-1:0] alu_B,
    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_pc,
    input  logic [XLEN-1:0] alu_C,
    input  logic [7:0]      alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic [XLEN-1:0] out_wdata,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_br_target,
    output logic            out_illegal
);
    state_t          state, state_n;
    logic [4:0]      d_op;
    logic            d_use_imm, d_branch, d_lui, d_auipc, d_illegal;
    logic [31:0]     d_imm;
    logic [2:0]      d_kind, kind_q;
    logic [XLEN-1:0] b_raw, a_eff, b_eff, tgt_q;
    logic [4:0]      rd_q;
    logic            br_q, accept, zero_unused;

    rv32_alu_decode u_dec (
        .instr     (in_instr),
        .alu_op    (d_op),
        .use_imm   (d_use_imm),
        .imm       (d_imm),
        .is_branch (d_branch),
        .br_kind   (d_kind),
        .is_lui    (d_lui),
        .is_auipc  (d_auipc),
        .illegal   (d_illegal)
    );

    assign in_ready    = state == ST_IDLE;
    assign accept      = in_ready & in_valid;
    assign zero_unused = ^alu_zero[7:1];
    assign b_raw       = d_use_imm ? d_imm : in_rs2_val;
    assign b_eff       = (d_op == ALU_SLL || d_op == ALU_SRL || d_op == ALU_SRA) ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
    assign a_eff       = (d_lui | d_auipc) ? '0 : in_rs1_val;

    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (in_valid) state_n = d_illegal ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_n = ST_CAPT;
            ST_CAPT:  state_n = ST_RESP;
            ST_RESP:  if (out_ready) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // alu_* load on accept so they are stable through ISSUE and hold afterwards
    always_ff @(posedge clk) begin
        if (!rstn) begin
            {alu_A, alu_B, alu_op, alu_pc} <= '0;
            {rd_q, br_q, kind_q, tgt_q} <= '0;
            {out_valid, out_rd, out_we, out_wdata, out_br_taken, out_br_target, out_illegal} <= '0;
        end else begin
            if (accept && !d_illegal) begin
                alu_A  <= a_eff;
                alu_B  <= b_eff;
                alu_op <= d_op;
                alu_pc <= in_pc;
                rd_q   <= d_branch ? 5'd0 : in_instr[11:7];
                br_q   <= d_branch;
                kind_q <= d_kind;
                tgt_q  <= in_pc + d_imm;
            end
            if (accept && d_illegal) begin
                {out_rd, out_we, out_wdata, out_br_taken, out_br_target} <= '0;
                out_illegal <= 1'b1;
                out_valid   <= 1'b1;
            end
            if (state == ST_CAPT) begin
                out_valid     <= 1'b1;
                out_illegal   <= 1'b0;
                out_rd        <= rd_q;
                out_we        <= !br_q && rd_q != 5'd0;
                out_wdata     <= br_q ? '0 : alu_C;
                out_br_taken  <= br_q & ((kind_q[2] ? alu_C[0] : alu_zero[0]) ^ kind_q[0]);
                out_br_target <= br_q ? tgt_q : '0;
            end
            if (state == ST_RESP && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random RV32I ops through the controller and a registered ALU stand-in.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_rs1_val = '0, in_rs2_val = '0, in_pc = '0;
    logic [31:0] alu_A, alu_B, alu_pc, alu_C, out_wdata, out_br_target, c_n;
    logic [4:0]  alu_op, out_rd;
    logic [7:0]  alu_zero;
    logic        out_we, out_br_taken, out_illegal;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_pc(in_pc),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_pc(alu_pc), .alu_C(alu_C), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_we(out_we), .out_wdata(out_wdata),
        .out_br_taken(out_br_taken), .out_br_target(out_br_target), .out_illegal(out_illegal)
    );

    // Registered ALU stand-in; upper Zero bits carry junk the controller must ignore
    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_SLT:   return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  return {31'b0, a < b};
            ALU_BLTU:  return {31'b0, a < b};
            ALU_XOR:   return a ^ b;
            ALU_OR:    return a | b;
            ALU_AND:   return a & b;
            ALU_SLL:   return a << b[4:0];
            ALU_SRL:   return a >> b[4:0];
            ALU_SRA:   return 32'($signed(a) >>> b[4:0]);
            ALU_LUI:   return b;
            ALU_AUIPC: return pc + b;
            default:   return 32'd0;
        endcase
    endfunction

    assign c_n = alu_f(alu_op, alu_A, alu_B, alu_pc);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            alu_C    <= '0;
            alu_zero <= '0;
        end else begin
            alu_C    <= c_n;
            alu_zero <= {7'h2a, c_n == 32'd0};
        end
    end

    typedef struct packed {
        logic        ill;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wd;
        logic        tk;
        logic [31:0] tg;
    } exp_t;

    // Architectural result straight from the RV32I definitions
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        exp_t        e;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] ii, iu, ib, y, v;
        logic        ok;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        ii  = {{20{ins[31]}}, ins[31:20]};
        iu  = {ins[31:12], 12'b0};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        y   = (opc == 7'h13) ? ii : b;
        e   = '0;
        ok  = 1'b0;
        v   = '0;
        case (opc)
            7'h37: begin ok = 1'b1; v = iu; end
            7'h17: begin ok = 1'b1; v = pc + iu; end
            7'h13, 7'h33: begin
                ok = (opc == 7'h33) ? (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
                   : (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                case (f3)
                    3'd0: v = (opc == 7'h33 && f7[5]) ? a - b : a + y;
                    3'd1: v = a << y[4:0];
                    3'd2: v = {31'b0, $signed(a) < $signed(y)};
                    3'd3: v = {31'b0, a < y};
                    3'd4: v = a ^ y;
                    3'd5: v = f7[5] ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
                    3'd6: v = a | y;
                    default: v = a & y;
                endcase
            end
            7'h63: ok = f3 != 3'd2 && f3 != 3'd3;
            default: ok = 1'b0;
        endcase
        if (!ok) e.ill = 1'b1;
        else if (opc == 7'h63) begin
            case (f3)
                3'd0: e.tk = a == b;
                3'd1: e.tk = a != b;
                3'd4: e.tk = $signed(a) < $signed(b);
                3'd5: e.tk = $signed(a) >= $signed(b);
                3'd6: e.tk = a < b;
                default: e.tk = a >= b;
            endcase
            e.tg = pc + ib;
        end else begin
            e.rd = ins[11:7];
            e.we = ins[11:7] != 5'd0;
            e.wd = v;
        end
        return e;
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return {r[31:7], 7'h37};
            1: return {r[31:7], 7'h17};
            2: return {(r[13:12] == 2'b01) ? {1'b0, r[30], 5'b0} : r[31:25], r[24:7], 7'h13};
            3: return {r[29] ? {1'b0, r[30], 5'b0} : r[31:25], r[24:7], 7'h33};
            4: return {r[31:7], 7'h63};
            default: return r;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc, input int hold);
        exp_t e;
        int   lat;
        e = model(ins, a, b, pc);
        in_instr = ins; in_rs1_val = a; in_rs2_val = b; in_pc = pc; in_valid = 1'b1;
        chk1("in_ready_idle", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk("latency", lat, e.ill ? 32'd1 : 32'd3);
        chk1("illegal", out_illegal, e.ill);
        chk("rd", {27'b0, out_rd}, {27'b0, e.rd});
        chk1("we", out_we, e.we);
        chk("wdata", out_wdata, e.wd);
        chk1("br_taken", out_br_taken, e.tk);
        chk("br_target", out_br_target, e.tg);
        repeat (hold) begin
            in_valid = 1'b1;
            in_instr = $urandom;
            tick();
            chk1("stall_valid", out_valid, 1'b1);
            chk1("stall_in_ready", in_ready, 1'b0);
            chk("stall_wdata", out_wdata, e.wd);
            chk("stall_target", out_br_target, e.tg);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("release_idle", in_ready, 1'b1);
        chk1("release_valid", out_valid, 1'b0);
    endtask

    initial begin
        repeat (3) tick();
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk("rst_alu_op", {27'b0, alu_op}, 32'd0);
        chk("rst_alu_A", alu_A, 32'd0);
        chk("rst_wdata", out_wdata, 32'd0);
        rstn = 1'b1;
        tick();
        run(32'hFFF00293, 32'd0, 32'd7, 32'h40, 0);
        run({7'h20, 5'd4, 5'd2, 3'd5, 5'd1, 7'h13}, 32'h80000000, 32'd0, 32'h44, 0);
        run({7'h00, 5'd5, 5'd4, 3'd1, 5'd3, 7'h33}, 32'h3, 32'h21, 32'h48, 0);
        run(enc_b(13'd8, 5'd2, 5'd1, 3'd4), 32'h80000000, 32'd1, 32'h100, 0);
        run(enc_b(13'd8, 5'd2, 5'd1, 3'd7), 32'h80000000, 32'd1, 32'h100, 0);
        run(enc_b(13'd8, 5'd2, 5'd1, 3'd0), 32'h1234, 32'h1234, 32'h200, 0);
        run(enc_b(13'd8, 5'd2, 5'd1, 3'd1), 32'h1234, 32'h1234, 32'h200, 0);
        run(enc_b(13'd8, 5'd2, 5'd1, 3'd0), 32'h5, 32'h6, 32'hFFFFFFFC, 0);
        run({7'h00, 5'd6, 5'd5, 3'd0, 5'd9, 7'h33}, 32'h11, 32'h22, 32'h50, 5);
        run(32'h0000006F, 32'd1, 32'd2, 32'h60, 2);
        run({20'hABCDE, 5'd0, 7'h37}, 32'd1, 32'd2, 32'h64, 0);
        // reset while the result is being captured
        in_instr = {7'h00, 5'd6, 5'd5, 3'd0, 5'd7, 7'h33};
        in_rs1_val = 32'd5; in_rs2_val = 32'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        chk1("midrst_valid", out_valid, 1'b0);
        chk("midrst_wdata", out_wdata, 32'd0);
        chk("midrst_rd", {27'b0, out_rd}, 32'd0);
        chk("midrst_alu_A", alu_A, 32'd0);
        chk("midrst_alu_op", {27'b0, alu_op}, 32'd0);
        rstn = 1'b1;
        repeat (4) begin
            tick();
            chk1("midrst_no_pulse", out_valid, 1'b0);
        end
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = $urandom;
            run(rnd_instr(), a, ($urandom_range(0, 3) == 0) ? a : $urandom, $urandom & 32'hFFFFFFFC, $urandom_range(0, 3));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
